// File: rtl/gsim_sched_if.sv
// rtl/gsim_sched_if.sv - control/issue/writeback bundle for the Gauss-Seidel scheduler
interface gsim_sched_if;
  logic        start;
  logic        hold;
  logic        busy;
  logic        done;
  logic        issue_valid;
  logic [3:0]  issue_row;
  logic [4:0]  issue_iter;
  logic        first_sweep;
  logic        wb_valid;
  logic [3:0]  wb_row;
  logic [15:0] stall_cnt;

  // Controller side: requests solves and throttles issue.
  modport master (
    output start, hold,
    input  busy, done, issue_valid, issue_row, issue_iter,
    input  first_sweep, wb_valid, wb_row, stall_cnt
  );

  // Scheduler side.
  modport slave (
    input  start, hold,
    output busy, done, issue_valid, issue_row, issue_iter,
    output first_sweep, wb_valid, wb_row, stall_cnt
  );
endinterface

// File: rtl/gsim_sched.sv
// rtl/gsim_sched.sv - Gauss-Seidel row-issue scheduler with hazard spacing and writeback tracking
module gsim_sched #(
  parameter int PIPE_LAT = 4,
  parameter int ITERS    = 16
) (
  input  logic         clk,
  input  logic         reset,
  gsim_sched_if.slave  ctl
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  localparam logic [3:0] LAT_V     = 4'(PIPE_LAT);
  localparam logic [4:0] LAST_ITER = 5'(ITERS - 1);

  state_t       state_q, state_d;
  logic [3:0]   row_q, row_d;
  logic [4:0]   iter_q, iter_d;
  logic [3:0]   timer_q, timer_d;
  logic [15:0]  stall_q, stall_d;
  logic [PIPE_LAT-1:0] sr_valid_q;
  logic [3:0]   sr_row_q [PIPE_LAT];

  logic issue;
  logic done;
  logic hazard;
  logic last_issue;

  // Row r must wait until row r-1 has cleared the datapath; row 0 has no
  // wrap-around neighbour so it never waits on the timer.
  assign hazard     = (row_q != 4'd0) && (timer_q != 4'd0);
  assign last_issue = (row_q == 4'd15) && (iter_q == LAST_ITER);

  // Next-state, issue decision and counter updates.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    iter_d  = iter_q;
    timer_d = (timer_q != 4'd0) ? timer_q - 4'd1 : 4'd0;
    stall_d = stall_q;
    issue   = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ctl.start) begin
          state_d = S_RUN;
          row_d   = 4'd0;
          iter_d  = 5'd0;
          timer_d = 4'd0;
          stall_d = 16'd0;
        end
      end
      S_RUN: begin
        issue = !ctl.hold && !hazard;
        if (issue) begin
          timer_d = LAT_V;
          row_d   = row_q + 4'd1;
          if (row_q == 4'd15) iter_d = iter_q + 5'd1;
          if (last_issue) state_d = S_DRAIN;
        end else if (stall_q != 16'hFFFF) begin
          stall_d = stall_q + 16'd1;
        end
      end
      S_DRAIN: begin
        // Pipeline empty means the final writeback retired last cycle.
        if (sr_valid_q == '0) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= 4'd0;
      iter_q  <= 5'd0;
      timer_q <= 4'd0;
      stall_q <= 16'd0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      iter_q  <= iter_d;
      timer_q <= timer_d;
      stall_q <= stall_d;
    end
  end

  // Writeback tracker: mirrors the datapath latency so wb appears PIPE_LAT cycles after issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_valid_q <= '0;
      for (int i = 0; i < PIPE_LAT; i++) sr_row_q[i] <= 4'd0;
    end else begin
      sr_valid_q[0] <= issue;
      sr_row_q[0]   <= row_q;
      for (int i = 1; i < PIPE_LAT; i++) begin
        sr_valid_q[i] <= sr_valid_q[i-1];
        sr_row_q[i]   <= sr_row_q[i-1];
      end
    end
  end

  assign ctl.busy        = (state_q != S_IDLE);
  assign ctl.done        = done;
  assign ctl.issue_valid = issue;
  assign ctl.issue_row   = row_q;
  assign ctl.issue_iter  = iter_q;
  assign ctl.first_sweep = issue && (iter_q == 5'd0);
  assign ctl.wb_valid    = sr_valid_q[PIPE_LAT-1];
  assign ctl.wb_row      = sr_row_q[PIPE_LAT-1];
  assign ctl.stall_cnt   = stall_q;

endmodule
